// File: rtl/tcam_search_ctrl.sv
// 16-entry ternary CAM controller: entry storage, write/invalidate/search sequencing,
// registered match lines and priority-encoded hit responses over a valid/ready handshake.
module tcam_search_ctrl #(
    parameter int unsigned KEY_W    = 8,
    parameter bit          HI_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [3:0]       cmd_addr_i,
    input  logic [KEY_W-1:0] cmd_key_i,
    input  logic [KEY_W-1:0] cmd_mask_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_hit_o,
    output logic [3:0]       rsp_addr_o,
    output logic             rsp_multi_o,
    output logic             rsp_last_o
);

    localparam int unsigned Entries = 16;

    typedef enum logic [1:0] {
        OpSearch    = 2'd0,
        OpSearchAll = 2'd1,
        OpWrite     = 2'd2,
        OpInval     = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StMatch,
        StResp
    } state_e;

    state_e               state_q, state_d;
    logic [KEY_W-1:0]     value_q [Entries];
    logic [KEY_W-1:0]     mask_q  [Entries];
    logic [Entries-1:0]   valid_q, valid_d;
    logic [Entries-1:0]   match_q, match_d;
    logic [Entries-1:0]   match_lines;
    logic [KEY_W-1:0]     key_q, key_d;
    logic                 all_q, all_d;
    logic                 multi_q, multi_d;
    logic                 wr_en;
    logic [3:0]           winner;
    logic                 one_left;

    always_comb begin
        for (int i = 0; i < Entries; i++) begin
            match_lines[i] = valid_q[i] && (((key_q ^ value_q[i]) & ~mask_q[i]) == '0);
        end
    end

    // Later loop iterations override earlier ones, so iteration order sets the priority.
    always_comb begin
        winner = '0;
        if (HI_FIRST) begin
            for (int i = 0; i < Entries; i++) begin
                if (match_q[i]) winner = 4'(i);
            end
        end else begin
            for (int i = Entries - 1; i >= 0; i--) begin
                if (match_q[i]) winner = 4'(i);
            end
        end
    end

    // Zero or one bit set: the current beat is the final one.
    assign one_left = (match_q & (match_q - 16'd1)) == '0;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        match_d = match_q;
        key_d   = key_q;
        all_d   = all_q;
        multi_d = multi_q;
        wr_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    case (op_e'(cmd_op_i))
                        OpWrite: begin
                            valid_d[cmd_addr_i] = 1'b1;
                            wr_en               = 1'b1;
                        end
                        OpInval: valid_d[cmd_addr_i] = 1'b0;
                        default: begin
                            key_d   = cmd_key_i;
                            all_d   = (op_e'(cmd_op_i) == OpSearchAll);
                            state_d = StMatch;
                        end
                    endcase
                end
            end
            StMatch: begin
                match_d = match_lines;
                multi_d = (match_lines & (match_lines - 16'd1)) != '0;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready_i) begin
                    match_d = match_q & ~(16'd1 << winner);
                    if (!all_q || one_left) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            valid_q <= '0;
            match_q <= '0;
            key_q   <= '0;
            all_q   <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            match_q <= match_d;
            key_q   <= key_d;
            all_q   <= all_d;
            multi_q <= multi_d;
        end
    end

    // Contents are qualified by valid_q, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            value_q[cmd_addr_i] <= cmd_key_i;
            mask_q[cmd_addr_i]  <= cmd_mask_i;
        end
    end

    assign cmd_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_hit_o   = rsp_valid_o && (match_q != '0);
    assign rsp_addr_o  = rsp_valid_o ? winner : 4'd0;
    assign rsp_multi_o = rsp_valid_o && multi_q;
    assign rsp_last_o  = rsp_valid_o && (!all_q || one_left);

endmodule
